fifo_sync_param: RTL and testbench



---
 rtl/fifo_sync_param.sv | 76 +++++++
 tb/tb_fifo_sync_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with first-word fall-through output, occupancy
// count, almost-full/empty thresholds, sticky error flags and synchronous flush.
module fifo_sync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_LEVEL = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LEVEL = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // The extra MSB on each pointer distinguishes full from empty when the
  // storage indices coincide.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= AF_LEVEL);
  assign almost_empty = (count <= AE_LEVEL);
  assign data_out     = mem[rd_ptr[AW-1:0]];

  // A simultaneous pop frees the head slot, so a push into a full FIFO is legal.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + CW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + CW'(1);
      if (push && full && !pop) overflow  <= 1'b1;
      if (pop && empty)         underflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // valid, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (!flush && push_ok) mem[wr_ptr[AW-1:0]] <= data_in;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param at default parameters.
module tb_fifo_sync_param;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       push;
  logic       pop;
  logic       flush;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  fifo_sync_param dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .push         (push),
    .pop          (pop),
    .flush        (flush),
    .data_in      (data_in),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling and driving.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " count"},        32'(count),        32'd0);
    check({tag, " empty"},        32'(empty),        32'd1);
    check({tag, " full"},         32'(full),         32'd0);
    check({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
    check({tag, " almost_full"},  32'(almost_full),  32'd0);
    check({tag, " overflow"},     32'(overflow),     32'd0);
    check({tag, " underflow"},    32'(underflow),    32'd0);
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; data_in = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge CLK);
    rst_n = 1'b1;

    // Fill with 0x11..0x88.
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; data_in = 8'((i + 1) * 8'h11);
      step();
      check("fill count",    32'(count),        32'(i + 1));
      check("fill empty",    32'(empty),        32'd0);
      check("fill full",     32'(full),         32'(i == 7));
      check("fill af",       32'(almost_full),  32'(i + 1 >= 6));
      check("fill ae",       32'(almost_empty), 32'(i + 1 <= 2));
      check("fill head",     32'(data_out),     32'h11);
    end

    // Push while full is rejected and sets sticky overflow.
    data_in = 8'h99;
    step();
    push = 1'b0;
    check("ovf flag",  32'(overflow), 32'd1);
    check("ovf count", 32'(count),    32'd8);
    check("ovf head",  32'(data_out), 32'h11);

    // Drain in order.
    pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain data", 32'(data_out), 32'((i + 1) * 8'h11));
      step();
    end
    pop = 1'b0;
    check("drain empty",    32'(empty),    32'd1);
    check("drain count",    32'(count),    32'd0);
    check("drain overflow", 32'(overflow), 32'd1);

    // Wrap-around: preload 3, then 20 simultaneous push+pop cycles.
    push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 8'(8'h20 + i);
      q.push_back(data_in);
      step();
    end
    pop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_in = 8'(8'h30 + i);
      check("wrap head", 32'(data_out), 32'(q[0]));
      void'(q.pop_front());
      q.push_back(data_in);
      step();
      check("wrap count", 32'(count), 32'd3);
    end
    push = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wrap tail", 32'(data_out), 32'(q[0]));
      void'(q.pop_front());
      step();
    end
    pop = 1'b0;
    check("wrap empty", 32'(empty), 32'd1);

    // Empty FIFO: pop alone underflows, push+pop accepts only the push.
    pop = 1'b1;
    step();
    check("unf flag",  32'(underflow), 32'd1);
    check("unf count", 32'(count),     32'd0);
    push = 1'b1; data_in = 8'hA5;
    step();
    push = 1'b0; pop = 1'b0;
    check("empty pp count", 32'(count),    32'd1);
    check("empty pp data",  32'(data_out), 32'hA5);
    check("empty pp empty", 32'(empty),    32'd0);
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("unf sticky", 32'(underflow), 32'd1);

    // Flush clears sticky flags.
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush ovf",   32'(overflow),  32'd0);
    check("flush unf",   32'(underflow), 32'd0);
    check("flush count", 32'(count),     32'd0);

    // Full FIFO: push+pop replaces head slot, count unchanged.
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'(8'h40 + i);
      step();
    end
    check("full2 full", 32'(full), 32'd1);
    pop = 1'b1; data_in = 8'hC3;
    check("full pp head", 32'(data_out), 32'h40);
    step();
    push = 1'b0;
    check("full pp count", 32'(count),    32'd8);
    check("full pp ovf",   32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("full pp order", 32'(data_out), (i == 7) ? 32'hC3 : 32'(8'h41 + i));
      step();
    end
    pop = 1'b0;
    check("full pp empty", 32'(empty), 32'd1);

    // Flush with push at count 5 and a pending underflow.
    pop = 1'b1;
    step();
    pop = 1'b0; push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'(8'h50 + i);
      step();
    end
    check("pre-flush count", 32'(count),     32'd5);
    check("pre-flush unf",   32'(underflow), 32'd1);
    flush = 1'b1; data_in = 8'hEE;
    step();
    flush = 1'b0; push = 1'b0;
    check("flush2 count", 32'(count),     32'd0);
    check("flush2 empty", 32'(empty),     32'd1);
    check("flush2 unf",   32'(underflow), 32'd0);
    check("flush2 ovf",   32'(overflow),  32'd0);

    // Asynchronous reset mid-stream, between clock edges.
    push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 8'(8'h60 + i);
      step();
    end
    check("pre-rst count", 32'(count), 32'd3);
    pop = 1'b1;
    step();
    pop = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst count", 32'(count),        32'd0);
    check("async rst empty", 32'(empty),        32'd1);
    check("async rst full",  32'(full),         32'd0);
    check("async rst ae",    32'(almost_empty), 32'd1);
    check("async rst af",    32'(almost_full),  32'd0);
    @(negedge CLK);
    check("rst held count", 32'(count), 32'd0);
    rst_n = 1'b1; push = 1'b0;
    step();
    check("post-rst count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
